// File: rtl/ascon_stream_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ascon_stream_sequencer
// Purpose  : Sequences one Ascon-128 operation from a single GO: key load,
//            AD blocks, MSG blocks, ciphertext to the output FIFO, tag latch.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_stream_sequencer #(
  parameter int pCNT_W  = 8,
  parameter int pWDOG_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [pCNT_W-1:0] ad_blocks,
  input  logic [pCNT_W-1:0] msg_blocks,
  input  logic [4:0]        ad_last_bytes,
  input  logic [4:0]        msg_last_bytes,
  input  logic              src_valid,
  input  logic [127:0]      src_data,
  output logic              src_ready,
  output logic              core_key_valid,
  input  logic              core_key_ready,
  output logic              core_bdi_valid,
  input  logic              core_bdi_ready,
  output logic [127:0]      core_bdi,
  output logic              core_bdi_type,
  output logic              core_bdi_last,
  output logic              core_bdi_eot,
  output logic [4:0]        core_bdi_bytes,
  input  logic              core_bdo_valid,
  input  logic [127:0]      core_bdo,
  input  logic              core_tag_valid,
  input  logic [127:0]      core_tag,
  output logic              fifo_wr_en,
  output logic [127:0]      fifo_wr_data,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              ovf,
  output logic [127:0]      tag_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY      = 3'd1,
    S_AD       = 3'd2,
    S_MSG      = 3'd3,
    S_WAIT_TAG = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  localparam logic [4:0]         c_FULL_BYTES = 5'd16;
  localparam logic [pCNT_W-1:0]  c_CNT_ONE    = pCNT_W'(1);
  localparam logic [pWDOG_W-1:0] c_WDOG_MAX   = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [pCNT_W-1:0]   r_ad_rem;
  logic [pCNT_W-1:0]   r_msg_rem;
  logic [pCNT_W-1:0]   w_ad_rem_nxt;
  logic [pCNT_W-1:0]   w_msg_rem_nxt;
  logic [4:0]          r_ad_last_bytes;
  logic [4:0]          r_msg_last_bytes;
  logic [pWDOG_W-1:0]  r_wdog;
  logic [pWDOG_W-1:0]  w_wdog_inc;
  logic                r_ovf;
  logic [127:0]        r_tag;
  logic                w_busy;
  logic                w_start_ok;
  logic                w_key_hs;
  logic                w_blk_hs;
  logic                w_tag_hs;
  logic                w_any_hs;
  logic                w_wdog_hit;

  assign w_busy     = (r_state == S_KEY) || (r_state == S_AD) ||
                      (r_state == S_MSG) || (r_state == S_WAIT_TAG);
  // abort beats start; start is only honoured from a resting state
  assign w_start_ok = start && !abort &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_any_hs   = w_key_hs || w_blk_hs || w_tag_hs;
  assign w_wdog_inc = r_wdog + 1'b1;
  // Fire on the cycle the stall count would reach all-ones.
  assign w_wdog_hit = (w_wdog_inc == c_WDOG_MAX);

  // Next-state, block qualifiers and handshake detection.
  always_comb begin
    w_state_nxt    = r_state;
    w_ad_rem_nxt   = r_ad_rem;
    w_msg_rem_nxt  = r_msg_rem;
    src_ready      = 1'b0;
    core_key_valid = 1'b0;
    core_bdi_valid = 1'b0;
    core_bdi       = '0;
    core_bdi_type  = 1'b0;
    core_bdi_last  = 1'b0;
    core_bdi_eot   = 1'b0;
    core_bdi_bytes = '0;
    w_key_hs       = 1'b0;
    w_blk_hs       = 1'b0;
    w_tag_hs       = 1'b0;
    case (r_state)
      S_KEY: begin
        core_key_valid = 1'b1;
        w_key_hs       = core_key_ready;
        if (core_key_ready) begin
          w_state_nxt = (r_ad_rem != '0) ? S_AD : S_MSG;
        end
      end
      S_AD: begin
        core_bdi_valid = src_valid;
        src_ready      = src_valid && core_bdi_ready;
        core_bdi       = src_data;
        core_bdi_last  = (r_ad_rem == c_CNT_ONE);
        core_bdi_bytes = core_bdi_last ? r_ad_last_bytes : c_FULL_BYTES;
        w_blk_hs       = src_valid && core_bdi_ready;
        if (w_blk_hs) begin
          w_ad_rem_nxt = r_ad_rem - c_CNT_ONE;
          if (core_bdi_last) begin
            w_state_nxt = S_MSG;
          end
        end
      end
      S_MSG: begin
        core_bdi_type = 1'b1;
        if (r_msg_rem == '0) begin
          // Empty message: one zero-length terminator, source untouched.
          core_bdi_valid = 1'b1;
          core_bdi_last  = 1'b1;
          core_bdi_eot   = 1'b1;
          w_blk_hs       = core_bdi_ready;
          if (core_bdi_ready) begin
            w_state_nxt = S_WAIT_TAG;
          end
        end else begin
          core_bdi_valid = src_valid;
          src_ready      = src_valid && core_bdi_ready;
          core_bdi       = src_data;
          core_bdi_last  = (r_msg_rem == c_CNT_ONE);
          core_bdi_eot   = core_bdi_last;
          core_bdi_bytes = core_bdi_last ? r_msg_last_bytes : c_FULL_BYTES;
          w_blk_hs       = src_valid && core_bdi_ready;
          if (w_blk_hs) begin
            w_msg_rem_nxt = r_msg_rem - c_CNT_ONE;
            if (core_bdi_last) begin
              w_state_nxt = S_WAIT_TAG;
            end
          end
        end
      end
      S_WAIT_TAG: begin
        w_tag_hs = core_tag_valid;
        if (core_tag_valid) begin
          w_state_nxt = S_DONE;
        end
      end
      default: ;
    endcase
    if (w_busy && !w_any_hs && w_wdog_hit) begin
      w_state_nxt = S_ERR;
    end
    if (w_start_ok) begin
      w_state_nxt = S_KEY;
    end
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Block counters and final-block byte counts, latched on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ad_rem         <= '0;
      r_msg_rem        <= '0;
      r_ad_last_bytes  <= '0;
      r_msg_last_bytes <= '0;
    end else if (w_start_ok) begin
      r_ad_rem         <= ad_blocks;
      r_msg_rem        <= msg_blocks;
      r_ad_last_bytes  <= ad_last_bytes;
      r_msg_last_bytes <= msg_last_bytes;
    end else begin
      r_ad_rem         <= w_ad_rem_nxt;
      r_msg_rem        <= w_msg_rem_nxt;
    end
  end

  // Stall watchdog: restarts on any handshake or state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_wdog <= '0;
    else if (!w_busy || w_any_hs || (w_state_nxt != r_state)) r_wdog <= '0;
    else                                                   r_wdog <= w_wdog_inc;
  end

  // Sticky overflow flag and tag latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_tag <= '0;
    end else if (abort || w_start_ok) begin
      r_ovf <= 1'b0;
      r_tag <= '0;
    end else begin
      if (core_bdo_valid && fifo_full) r_ovf <= 1'b1;
      if (w_tag_hs)                    r_tag <= core_tag;
    end
  end

  // Ciphertext goes straight to the FIFO; gated by reset so it drops at once.
  assign fifo_wr_en   = rst_n && core_bdo_valid && !fifo_full;
  assign fifo_wr_data = fifo_wr_en ? core_bdo : '0;

  assign busy    = w_busy;
  assign done    = (r_state == S_DONE);
  assign error   = (r_state == S_ERR);
  assign ovf     = r_ovf;
  assign tag_out = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_ascon_stream_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ascon_stream_sequencer
// Purpose  : Directed bench with a small cycle-level core/source model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_stream_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [7:0]   ad_blocks, msg_blocks;
  logic [4:0]   ad_last_bytes, msg_last_bytes;
  logic         src_valid;
  logic [127:0] src_data;
  logic         src_ready;
  logic         core_key_valid, core_key_ready;
  logic         core_bdi_valid, core_bdi_ready;
  logic [127:0] core_bdi;
  logic         core_bdi_type, core_bdi_last, core_bdi_eot;
  logic [4:0]   core_bdi_bytes;
  logic         core_bdo_valid;
  logic [127:0] core_bdo;
  logic         core_tag_valid;
  logic [127:0] core_tag;
  logic         fifo_wr_en;
  logic [127:0] fifo_wr_data;
  logic         fifo_full;
  logic         busy, done, error, ovf;
  logic [127:0] tag_out;

  ascon_stream_sequencer #(.pCNT_W(8), .pWDOG_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ad_blocks(ad_blocks), .msg_blocks(msg_blocks),
    .ad_last_bytes(ad_last_bytes), .msg_last_bytes(msg_last_bytes),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .core_key_valid(core_key_valid), .core_key_ready(core_key_ready),
    .core_bdi_valid(core_bdi_valid), .core_bdi_ready(core_bdi_ready),
    .core_bdi(core_bdi), .core_bdi_type(core_bdi_type),
    .core_bdi_last(core_bdi_last), .core_bdi_eot(core_bdi_eot),
    .core_bdi_bytes(core_bdi_bytes),
    .core_bdo_valid(core_bdo_valid), .core_bdo(core_bdo),
    .core_tag_valid(core_tag_valid), .core_tag(core_tag),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .busy(busy), .done(done), .error(error), .ovf(ovf), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] c_TAG = 128'h7A67_D00D_1234_5678_9ABC_DEF0_0F1E_2D3C;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model / run bookkeeping
  logic [15:0]  rdy_pat;
  logic         rdy_stall;
  logic         tag_en;
  int           full_idx;
  logic [1:0]   sr_ct;
  logic [2:0]   sr_tag;
  int           ct_issued, src_idx, n_rec, n_src, n_wr;
  int           eot_edge, done_edge, err_edge;
  logic [127:0] rec_data [32];
  logic         rec_type [32];
  logic         rec_last [32];
  logic         rec_eot  [32];
  logic [4:0]   rec_bytes[32];
  logic [127:0] wr_log   [8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask

  function automatic logic [127:0] mkdata(input int i);
    return {96'h00010203_04050607_08090a0b, 32'h0c0d0e0f + i[31:0]};
  endfunction

  function automatic logic [127:0] mkct(input int i);
    return {96'hC0FFEE00_11223344_55667788, i[31:0]};
  endfunction

  // One clock: sample settled outputs, cross the edge, update the model.
  task automatic tick();
    logic s_hs, s_type, s_last, s_eot, s_src, s_wr;
    logic [4:0]   s_bytes;
    logic [127:0] s_data, s_wdata;
    s_hs    = core_bdi_valid & core_bdi_ready;
    s_type  = core_bdi_type;
    s_last  = core_bdi_last;
    s_eot   = core_bdi_eot;
    s_bytes = core_bdi_bytes;
    s_data  = core_bdi;
    s_src   = src_ready;
    s_wr    = fifo_wr_en;
    s_wdata = fifo_wr_data;
    if (s_hs && n_rec < 32) begin
      rec_data[n_rec] = s_data;  rec_type[n_rec]  = s_type;
      rec_last[n_rec] = s_last;  rec_eot[n_rec]   = s_eot;
      rec_bytes[n_rec] = s_bytes;
      n_rec++;
    end
    if (s_src) n_src++;
    if (s_wr) begin
      if (n_wr < 8) wr_log[n_wr] = s_wdata;
      n_wr++;
    end
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (s_hs && s_eot) eot_edge = cyc;
    if (s_src) src_idx++;
    src_data       = mkdata(src_idx);
    sr_ct          = {sr_ct[0], s_hs & s_type & (s_bytes != 5'd0)};
    sr_tag         = {sr_tag[1:0], s_hs & s_eot};
    core_bdo_valid = sr_ct[1];
    core_bdo       = mkct(ct_issued);
    fifo_full      = sr_ct[1] && (ct_issued == full_idx);
    if (sr_ct[1]) ct_issued++;
    core_tag_valid = sr_tag[2] & tag_en;
    core_bdi_ready = rdy_stall ? rdy_pat[cyc[3:0]] : 1'b1;
    if (done  && done_edge < 0) done_edge = cyc;
    if (error && err_edge  < 0) err_edge  = cyc;
    #1;
  endtask

  task automatic begin_run(input logic [7:0] na, input logic [7:0] nm,
                           input logic [4:0] la, input logic [4:0] lm);
    n_rec = 0; n_src = 0; n_wr = 0; src_idx = 0; ct_issued = 0;
    eot_edge = -1; done_edge = -1; err_edge = -1;
    src_data = mkdata(0);
    ad_blocks = na; msg_blocks = nm; ad_last_bytes = la; msg_last_bytes = lm;
    start = 1'b1;
    tick();
  endtask

  task automatic run_until_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!(done || error) && k < bound) begin
      tick();
      k++;
    end
    check(tag, 128'(done | error), 128'(1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ad_blocks = '0; msg_blocks = '0; ad_last_bytes = '0; msg_last_bytes = '0;
    src_valid = 1'b1; src_data = '0;
    core_key_ready = 1'b1; core_bdi_ready = 1'b1;
    core_bdo_valid = 1'b0; core_bdo = '0; core_tag_valid = 1'b0; core_tag = c_TAG;
    fifo_full = 1'b0;
    rdy_pat = 16'b1011_0110_1101_0011; rdy_stall = 1'b0; tag_en = 1'b1;
    full_idx = -1; sr_ct = '0; sr_tag = '0;
    ct_issued = 0; src_idx = 0; n_rec = 0; n_src = 0; n_wr = 0;
    eot_edge = -1; done_edge = -1; err_edge = -1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 128'({busy, done, error, ovf, src_ready, core_key_valid,
                               core_bdi_valid, fifo_wr_en}), 128'(0));
    check("reset_tag", tag_out, 128'(0));
    rst_n = 1'b1;
    #1;

    // 1 AD + 1 MSG, 16 bytes each, always ready
    begin_run(8'd1, 8'd1, 5'd16, 5'd16);
    check("t1_key_after_start", 128'({busy, core_key_valid}), 128'(2'b11));
    run_until_done("t1_finish", 100);
    check("t1_blocks", 128'(n_rec), 128'(2));
    check("t1_ad_qual", 128'({rec_type[0], rec_last[0], rec_bytes[0]}), 128'({1'b0, 1'b1, 5'd16}));
    check("t1_ad_data", rec_data[0], 128'h00010203_04050607_08090a0b_0c0d0e0f);
    check("t1_msg_qual", 128'({rec_type[1], rec_last[1], rec_eot[1], rec_bytes[1]}),
          128'({1'b1, 1'b1, 1'b1, 5'd16}));
    check("t1_fifo_writes", 128'(n_wr), 128'(1));
    check("t1_fifo_data", wr_log[0], mkct(0));
    check("t1_done_latency", 128'(done_edge - eot_edge), 128'(3));
    check("t1_tag", tag_out, c_TAG);

    // 3 AD + 2 MSG, last bytes 5 and 9, ready stalls
    rdy_stall = 1'b1;
    begin_run(8'd3, 8'd2, 5'd5, 5'd9);
    run_until_done("t2_finish", 200);
    rdy_stall = 1'b0;
    check("t2_blocks", 128'(n_rec), 128'(5));
    check("t2_last", 128'({rec_last[4], rec_last[3], rec_last[2], rec_last[1], rec_last[0]}),
          128'(5'b10100));
    check("t2_type", 128'({rec_type[4], rec_type[3], rec_type[2], rec_type[1], rec_type[0]}),
          128'(5'b11000));
    check("t2_bytes", 128'({rec_bytes[4], rec_bytes[2], rec_bytes[0]}), 128'({5'd9, 5'd5, 5'd16}));
    check("t2_eot", 128'({rec_eot[4], rec_eot[3]}), 128'(2'b10));
    check("t2_msg_data", rec_data[3], mkdata(3));
    check("t2_src_ready", 128'(n_src), 128'(5));
    check("t2_fifo_writes", 128'(n_wr), 128'(2));

    // no AD, empty message
    begin_run(8'd0, 8'd0, 5'd16, 5'd16);
    run_until_done("t3_finish", 100);
    check("t3_blocks", 128'(n_rec), 128'(1));
    check("t3_synth_qual", 128'({rec_type[0], rec_last[0], rec_eot[0], rec_bytes[0]}),
          128'({1'b1, 1'b1, 1'b1, 5'd0}));
    check("t3_synth_data", rec_data[0], 128'(0));
    check("t3_src_ready", 128'(n_src), 128'(0));
    check("t3_done", 128'({done, error}), 128'(2'b10));

    // FIFO full on the 2nd of 3 ciphertext blocks
    full_idx = 1;
    begin_run(8'd1, 8'd3, 5'd16, 5'd7);
    run_until_done("t4_finish", 100);
    full_idx = -1;
    check("t4_fifo_writes", 128'(n_wr), 128'(2));
    check("t4_fifo_data2", wr_log[1], mkct(2));
    check("t4_ovf_done", 128'({done, ovf}), 128'(2'b11));

    // tag never arrives: watchdog
    tag_en = 1'b0;
    begin_run(8'd0, 8'd1, 5'd16, 5'd4);
    check("t5_ovf_cleared", 128'(ovf), 128'(0));
    run_until_done("t5_finish", 5000);
    check("t5_wdog_cycles", 128'(err_edge - eot_edge), 128'(4095));
    check("t5_err_flags", 128'({error, busy, done}), 128'(3'b100));
    tag_en = 1'b1;
    begin_run(8'd1, 8'd1, 5'd16, 5'd16);
    run_until_done("t5_recover_finish", 100);
    check("t5_recover", 128'({done, error}), 128'(2'b10));
    check("t5_recover_tag", tag_out, c_TAG);

    // start while busy is ignored
    begin_run(8'd2, 8'd2, 5'd16, 5'd16);
    tick();
    ad_blocks = 8'd7; msg_blocks = 8'd7; ad_last_bytes = 5'd3; msg_last_bytes = 5'd3;
    start = 1'b1;
    tick();
    run_until_done("t8_finish", 100);
    check("t8_blocks", 128'(n_rec), 128'(4));
    check("t8_last", 128'({rec_last[3], rec_last[2], rec_last[1], rec_last[0]}), 128'(4'b1010));
    check("t8_bytes", 128'({rec_bytes[1], rec_bytes[3]}), 128'({5'd16, 5'd16}));

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    check("t9_abort_wins", 128'({busy, done, error}), 128'(0));

    // abort during MSG
    begin_run(8'd1, 8'd4, 5'd16, 5'd16);
    tick(); tick(); tick();
    check("t6_in_msg", 128'({busy, core_bdi_type, core_bdi_valid}), 128'(3'b111));
    abort = 1'b1;
    tick();
    check("t6_abort_flags", 128'({busy, done, error, src_ready, core_key_valid, core_bdi_valid,
                                  core_bdi_type, core_bdi_last, core_bdi_eot, core_bdi_bytes, ovf}),
          128'(0));
    check("t6_abort_data", core_bdi, 128'(0));
    check("t6_abort_tag", tag_out, 128'(0));
    repeat (4) tick();

    // asynchronous reset mid-operation
    begin_run(8'd1, 8'd2, 5'd16, 5'd16);
    tick(); tick();
    core_bdo_valid = 1'b1; fifo_full = 1'b0;
    #1;
    check("t7_wr_before_reset", 128'({fifo_wr_en, busy}), 128'(2'b11));
    rst_n = 1'b0;
    #1;
    check("t7_reset_immediate", 128'({fifo_wr_en, busy, src_ready, core_bdi_valid, core_key_valid}),
          128'(0));
    check("t7_reset_data", fifo_wr_data, 128'(0));
    core_bdo_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("t7_idle_after", 128'({busy, done, error, ovf}), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
